// File: rtl/spi_xfer_seq.sv
// -----------------------------------------------------------------------------
// spi_xfer_seq
//
// Transaction sequencer for the SPI host register port. It accepts one
// transfer descriptor, programs divider, slave-select and control once, then
// for each byte writes TX, sets GO, waits for the core's completion interrupt
// and reads RX back. The client sees valid/ready byte streams for TX and RX.
//
// Optional feature macro: SPI_SEQ_TIMEOUT_EN
//   defined   - a 16-bit watchdog runs in WAIT_DONE. After TIMEOUT cycles with
//               no interrupt, it rewrites CTRL with GO cleared, pulses err_o,
//               drops the remaining bytes and returns to IDLE without done_o.
//   undefined - WAIT_DONE waits indefinitely and err_o is tied low.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  descriptor handshake (ready only in IDLE)
//   req_len_i                  byte count minus one
//   req_div_i, req_ss_i        divider value, slave-select mask
//   req_ctrl_i                 control word template (GO/IE bits ignored)
//   tx_valid_i / tx_ready_o    TX byte stream, data on tx_data_i
//   rx_valid_o / rx_ready_i    RX byte stream, data on rx_data_o
//   busy_o                     sequencer is not IDLE
//   done_o                     one-cycle pulse at the end of a transfer
//   err_o                      one-cycle pulse on a watchdog abort
//   bus_*                      SPI core register port (single-cycle strobes)
//   bus_rdata_i                core read data, valid one cycle after the read
//   intr_i                     OR of the core TX/RX interrupt pulses
// -----------------------------------------------------------------------------
module spi_xfer_seq #(
   parameter logic [7:0]  DIV_OFS  = 8'h14,
   parameter logic [7:0]  CTRL_OFS = 8'h10,
   parameter logic [7:0]  SS_OFS   = 8'h18,
   parameter logic [7:0]  TX_OFS   = 8'h00,
   parameter logic [7:0]  RX_OFS   = 8'h00,
   parameter int unsigned GO_BIT   = 8,
   parameter int unsigned IE_BIT   = 12,
   parameter int unsigned TIMEOUT  = 4096
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [7:0]  req_len_i,
   input  logic [15:0] req_div_i,
   input  logic [7:0]  req_ss_i,
   input  logic [31:0] req_ctrl_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   input  logic [7:0]  tx_data_i,
   output logic        rx_valid_o,
   input  logic        rx_ready_i,
   output logic [7:0]  rx_data_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [7:0]  bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   output logic        bus_we_o,
   output logic        bus_re_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        intr_i
);

   localparam logic [31:0] GO_MASK = 32'(1) << GO_BIT;
   localparam logic [31:0] IE_MASK = 32'(1) << IE_BIT;

   typedef enum logic [3:0] {
      S_IDLE, S_CFG_DIV, S_CFG_SS, S_CFG_CTRL, S_GET_TX, S_WR_TX, S_WR_CTRL,
      S_WAIT_DONE, S_RD_ADDR, S_RD_CAP, S_PUSH_RX, S_FIN, S_ABORT
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  len_q;
   logic [15:0] div_q;
   logic [7:0]  ss_q;
   logic [31:0] ctrl_q;      // template with GO and IE already cleared
   logic [7:0]  cnt_q;       // index of the byte in flight
   logic [7:0]  tx_byte_q;
   logic [7:0]  rx_byte_q;
   logic        armed_q;     // keeps req_ready_o low while rst_ni is asserted
   logic        last_byte;

   // Only the low byte of the RX register carries data.
   logic unused_rdata;
   assign unused_rdata = ^bus_rdata_i[31:8];

   assign req_ready_o = (state_q == S_IDLE) && armed_q;
   assign busy_o      = (state_q != S_IDLE);
   assign rx_data_o   = rx_byte_q;
   assign last_byte   = (cnt_q == len_q);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: the datapath registers are few and all get an async reset so every
   // output, including rx_data_o, is a defined 0 while rst_ni is low.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         armed_q   <= 1'b0;
         len_q     <= '0;
         div_q     <= '0;
         ss_q      <= '0;
         ctrl_q    <= '0;
         cnt_q     <= '0;
         tx_byte_q <= '0;
         rx_byte_q <= '0;
      end else begin
         armed_q <= 1'b1;
         if (req_valid_i && req_ready_o) begin
            len_q  <= req_len_i;
            div_q  <= req_div_i;
            ss_q   <= req_ss_i;
            ctrl_q <= req_ctrl_i & ~(GO_MASK | IE_MASK);
            cnt_q  <= '0;
         end
         if (state_q == S_GET_TX && tx_valid_i) begin
            tx_byte_q <= tx_data_i;
         end
         if (state_q == S_RD_CAP) begin
            rx_byte_q <= bus_rdata_i[7:0];
         end
         // Saturates at the final byte, so a 256-byte transfer never wraps.
         if (state_q == S_PUSH_RX && rx_ready_i && !last_byte) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] to_cnt_q;

   // Cleared on the way into WAIT_DONE, counts every cycle spent there.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt_q <= '0;
      end else if (state_q == S_WR_CTRL) begin
         to_cnt_q <= '0;
      end else if (state_q == S_WAIT_DONE) begin
         to_cnt_q <= to_cnt_q + 16'd1;
      end
   end
`endif

   // NOTE: every combinational output gets a default before the case so that
   // no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      tx_ready_o  = 1'b0;
      rx_valid_o  = 1'b0;
      done_o      = 1'b0;
      err_o       = 1'b0;
      bus_addr_o  = '0;
      bus_wdata_o = '0;
      bus_be_o    = '0;
      bus_we_o    = 1'b0;
      bus_re_o    = 1'b0;
      unique case (state_q)
         S_IDLE: if (req_valid_i && req_ready_o) state_d = S_CFG_DIV;
         S_CFG_DIV: begin
            bus_we_o    = 1'b1;
            bus_addr_o  = DIV_OFS;
            bus_be_o    = 4'b0011;
            bus_wdata_o = {16'b0, div_q};
            state_d     = S_CFG_SS;
         end
         S_CFG_SS: begin
            bus_we_o    = 1'b1;
            bus_addr_o  = SS_OFS;
            bus_be_o    = 4'b0001;
            bus_wdata_o = {24'b0, ss_q};
            state_d     = S_CFG_CTRL;
         end
         // TX must be enabled in the core before the first byte is written.
         S_CFG_CTRL: begin
            bus_we_o    = 1'b1;
            bus_addr_o  = CTRL_OFS;
            bus_be_o    = 4'b1111;
            bus_wdata_o = ctrl_q;
            state_d     = S_GET_TX;
         end
         S_GET_TX: begin
            tx_ready_o = 1'b1;
            if (tx_valid_i) state_d = S_WR_TX;
         end
         S_WR_TX: begin
            bus_we_o    = 1'b1;
            bus_addr_o  = TX_OFS;
            bus_be_o    = 4'b0001;
            bus_wdata_o = {24'b0, tx_byte_q};
            state_d     = S_WR_CTRL;
         end
         S_WR_CTRL: begin
            bus_we_o    = 1'b1;
            bus_addr_o  = CTRL_OFS;
            bus_be_o    = 4'b1111;
            bus_wdata_o = ctrl_q | GO_MASK | IE_MASK;
            state_d     = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (intr_i) begin
               state_d = S_RD_ADDR;
`ifdef SPI_SEQ_TIMEOUT_EN
            end else if (to_cnt_q == TO_LAST) begin
               state_d = S_ABORT;
`endif
            end
         end
         S_RD_ADDR: begin
            bus_re_o   = 1'b1;
            bus_addr_o = RX_OFS;
            state_d    = S_RD_CAP;
         end
         S_RD_CAP: state_d = S_PUSH_RX;
         S_PUSH_RX: begin
            rx_valid_o = 1'b1;
            if (rx_ready_i) state_d = last_byte ? S_FIN : S_GET_TX;
         end
         S_FIN: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
`ifdef SPI_SEQ_TIMEOUT_EN
         // Stop the core with GO cleared, then drop the rest of the transfer.
         S_ABORT: begin
            bus_we_o    = 1'b1;
            bus_addr_o  = CTRL_OFS;
            bus_be_o    = 4'b1111;
            bus_wdata_o = ctrl_q;
            err_o       = 1'b1;
            state_d     = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_seq
//
// Self-checking bench for spi_xfer_seq. A small SPI core model answers the
// register port (interrupt a programmable delay after each GO, RX data one
// cycle after the read strobe) and records every bus write, RX handshake and
// done/err pulse. Each scenario task compares the recorded activity against
// the register-write list and byte stream the transfer rules call for.
// -----------------------------------------------------------------------------
module tb_spi_xfer_seq;

   localparam logic [7:0]  DIV_OFS    = 8'h14;
   localparam logic [7:0]  CTRL_OFS   = 8'h10;
   localparam logic [7:0]  SS_OFS     = 8'h18;
   localparam logic [7:0]  TX_OFS     = 8'h00;
   localparam logic [7:0]  RX_OFS     = 8'h00;
   localparam int unsigned GO_BIT     = 8;
   localparam int unsigned IE_BIT     = 12;
   localparam int unsigned TB_TIMEOUT = 64;
   localparam logic [31:0] GO_IE      = (32'd1 << GO_BIT) | (32'd1 << IE_BIT);
   localparam int          LIM        = 3000;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [7:0]  req_len_i = '0;
   logic [15:0] req_div_i = '0;
   logic [7:0]  req_ss_i = '0;
   logic [31:0] req_ctrl_i = '0;
   logic        tx_valid_i = 1'b0;
   logic        tx_ready_o;
   logic [7:0]  tx_data_i = '0;
   logic        rx_valid_o;
   logic        rx_ready_i = 1'b1;
   logic [7:0]  rx_data_o;
   logic        busy_o, done_o, err_o;
   logic [7:0]  bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_we_o, bus_re_o;
   logic [31:0] bus_rdata_i = '0;
   logic        intr_i = 1'b0;

   spi_xfer_seq #(
      .DIV_OFS(DIV_OFS), .CTRL_OFS(CTRL_OFS), .SS_OFS(SS_OFS),
      .TX_OFS(TX_OFS), .RX_OFS(RX_OFS), .GO_BIT(GO_BIT), .IE_BIT(IE_BIT),
      .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_len_i(req_len_i), .req_div_i(req_div_i), .req_ss_i(req_ss_i),
      .req_ctrl_i(req_ctrl_i),
      .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
      .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
      .bus_we_o(bus_we_o), .bus_re_o(bus_re_o), .bus_rdata_i(bus_rdata_i),
      .intr_i(intr_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   // Core model and monitor state.
   wr_t         wr_q[$];
   int          wr_cyc[$];
   logic [7:0]  rx_got[$];
   int          rx_cyc[$];
   int          done_cnt, done_cyc, err_cnt, err_cyc, strobe_cnt;
   int          intr_delay, countdown, rd_idx;
   bit          rd_pend, spurious_arm;
   logic [31:0] rnd;
   logic [7:0]  core_rx[256];
   logic [7:0]  tx_bytes[256];

   always @(posedge clk) cyc++;

   // Runs mid-way between the falling and rising edges: DUT outputs are
   // settled and the tasks have already updated the inputs for this cycle.
   always begin
      @(negedge clk);
      #2;
      intr_i = 1'b0;
      if (!rst_ni) begin
         countdown = 0;
         rd_pend   = 1'b0;
      end else begin
         n_checks++;
         if ((bus_we_o && bus_re_o) ||
             (!bus_we_o && !bus_re_o && (bus_addr_o != 0 || bus_wdata_o != 0 || bus_be_o != 0)) ||
             (bus_re_o && bus_addr_o !== RX_OFS)) begin
            n_fail++;
            $display("FAIL bus_protocol cyc=%0d: we=%b re=%b addr=%h wdata=%h be=%h, required exclusive strobes and zero idle bus",
                     cyc, bus_we_o, bus_re_o, bus_addr_o, bus_wdata_o, bus_be_o);
         end
         rnd = $urandom;
         if (rd_pend) begin
            bus_rdata_i = {rnd[31:8], core_rx[rd_idx[7:0]]};
            rd_idx++;
            rd_pend = 1'b0;
         end else begin
            bus_rdata_i = rnd;
         end
         if (bus_re_o) begin
            rd_pend = 1'b1;
            strobe_cnt++;
         end
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) intr_i = 1'b1;
         end
         if (bus_we_o) begin
            wr_q.push_back('{addr: bus_addr_o, wdata: bus_wdata_o, be: bus_be_o});
            wr_cyc.push_back(cyc);
            strobe_cnt++;
            if (bus_addr_o == CTRL_OFS && bus_wdata_o[GO_BIT] && intr_delay > 0)
               countdown = intr_delay;
            if (spurious_arm && bus_addr_o == DIV_OFS) begin
               intr_i       = 1'b1;
               spurious_arm = 1'b0;
            end
         end
         if (rx_valid_o && rx_ready_i) begin
            rx_got.push_back(rx_data_o);
            rx_cyc.push_back(cyc);
         end
         if (done_o) begin done_cnt++; done_cyc = cyc; end
         if (err_o)  begin err_cnt++;  err_cyc  = cyc; end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic clear_log();
      wr_q.delete(); wr_cyc.delete(); rx_got.delete(); rx_cyc.delete();
      done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1; rd_idx = 0;
   endtask

   // Presents a descriptor; returns the cycle in which it is accepted.
   task automatic send_desc(input logic [7:0] len, input logic [15:0] div,
                            input logic [7:0] ss, input logic [31:0] ctrl,
                            output int acc);
      int n = 0;
      req_valid_i = 1'b1; req_len_i = len; req_div_i = div;
      req_ss_i = ss; req_ctrl_i = ctrl;
      while (!req_ready_o && n < LIM) begin @(negedge clk); n++; end
      acc = cyc;
      n_checks++;
      if (!req_ready_o) begin
         n_fail++; acc = -1;
         $display("FAIL desc_accept: req_ready_o=%b after %0d cycles, required 1", req_ready_o, n);
      end
      @(negedge clk);
      req_valid_i = 1'b0;
      req_len_i = 8'($urandom); req_div_i = 16'($urandom);
      req_ss_i = 8'($urandom); req_ctrl_i = $urandom;
      n_checks++;
      if (busy_o !== 1'b1 || req_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_after_accept: busy=%b ready=%b, required busy=1 ready=0", busy_o, req_ready_o);
      end
   endtask

   task automatic feed_tx(input int nbytes, input int stall_idx, input int stall_cyc);
      for (int i = 0; i < nbytes; i++) begin
         int n = 0;
         if (i == stall_idx) begin
            int w0;
            tx_valid_i = 1'b0;
            while (!tx_ready_o && n < LIM) begin @(negedge clk); n++; end
            w0 = strobe_cnt;
            for (int k = 0; k < stall_cyc; k++) @(negedge clk);
            n_checks++;
            if (!tx_ready_o || strobe_cnt != w0) begin
               n_fail++;
               $display("FAIL tx_stall byte %0d: tx_ready=%b strobes=%0d, required tx_ready=1 strobes=%0d",
                        i, tx_ready_o, strobe_cnt, w0);
            end
            n = 0;
         end
         tx_valid_i = 1'b1;
         tx_data_i  = tx_bytes[i];
         while (!tx_ready_o && n < LIM) begin @(negedge clk); n++; end
         if (!tx_ready_o) begin
            n_checks++; n_fail++;
            $display("FAIL tx_handshake byte %0d: tx_ready_o=0 after %0d cycles, required 1", i, n);
            tx_valid_i = 1'b0;
            return;
         end
         @(negedge clk);
         tx_valid_i = 1'b0;
         tx_data_i  = 8'($urandom);
      end
   endtask

   task automatic drain_rx(input int nbytes, input int stall_idx, input int stall_cyc);
      for (int i = 0; i < nbytes; i++) begin
         int n = 0;
         rx_ready_i = (i != stall_idx);
         while (!rx_valid_o && n < LIM) begin @(negedge clk); n++; end
         if (!rx_valid_o) begin
            n_checks++; n_fail++;
            $display("FAIL rx_handshake byte %0d: rx_valid_o=0 after %0d cycles, required 1", i, n);
            rx_ready_i = 1'b1;
            return;
         end
         if (i == stall_idx) begin
            int w0 = strobe_cnt;
            for (int k = 0; k < stall_cyc; k++) begin
               @(negedge clk);
               n_checks++;
               if (rx_valid_o !== 1'b1 || rx_data_o !== core_rx[i]) begin
                  n_fail++;
                  $display("FAIL rx_hold byte %0d: valid=%b data=%h, required valid=1 data=%h",
                           i, rx_valid_o, rx_data_o, core_rx[i]);
               end
            end
            n_checks++;
            if (strobe_cnt != w0) begin
               n_fail++;
               $display("FAIL rx_stall_quiet byte %0d: strobes=%0d, required %0d", i, strobe_cnt, w0);
            end
            rx_ready_i = 1'b1;
         end
         @(negedge clk);
      end
      rx_ready_i = 1'b1;
   endtask

   // One complete transfer; tx_bytes/core_rx hold the byte streams.
   task automatic run_xfer(input string name, input logic [7:0] len, input int dly,
                           input int tx_si, input int tx_sc, input int rx_si, input int rx_sc);
      logic [15:0] div  = 16'($urandom);
      logic [7:0]  ss   = 8'($urandom);
      logic [31:0] ctrl = $urandom;
      wr_t exp_q[$];
      int  acc, n, nb;
      nb = int'(len) + 1;
      clear_log();
      intr_delay = dly;
      exp_q.push_back('{addr: DIV_OFS, wdata: {16'b0, div}, be: 4'b0011});
      exp_q.push_back('{addr: SS_OFS, wdata: {24'b0, ss}, be: 4'b0001});
      exp_q.push_back('{addr: CTRL_OFS, wdata: ctrl & ~GO_IE, be: 4'b1111});
      for (int i = 0; i < nb; i++) begin
         exp_q.push_back('{addr: TX_OFS, wdata: {24'b0, tx_bytes[i]}, be: 4'b0001});
         exp_q.push_back('{addr: CTRL_OFS, wdata: ctrl | GO_IE, be: 4'b1111});
      end
      send_desc(len, div, ss, ctrl, acc);
      fork
         feed_tx(nb, tx_si, tx_sc);
         drain_rx(nb, rx_si, rx_sc);
      join
      n = 0;
      while (done_cnt == 0 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      n_checks++;
      if (wr_q.size() == 0 || wr_cyc[0] != acc + 1) begin
         n_fail++;
         $display("FAIL %s first_write: cycle %0d, required %0d", name,
                  (wr_q.size() == 0) ? -1 : wr_cyc[0], acc + 1);
      end
      n_checks++;
      if (wr_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL %s write_count: %0d writes, required %0d", name, wr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         n_checks++;
         if (wr_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s write[%0d]: addr=%h data=%h be=%h, required addr=%h data=%h be=%h",
                     name, i, wr_q[i].addr, wr_q[i].wdata, wr_q[i].be,
                     exp_q[i].addr, exp_q[i].wdata, exp_q[i].be);
         end
      end
      n_checks++;
      if (rx_got.size() != nb) begin
         n_fail++;
         $display("FAIL %s rx_count: %0d bytes, required %0d", name, rx_got.size(), nb);
      end
      for (int i = 0; i < nb && i < rx_got.size(); i++) begin
         n_checks++;
         if (rx_got[i] !== core_rx[i]) begin
            n_fail++;
            $display("FAIL %s rx[%0d]: %h, required %h", name, i, rx_got[i], core_rx[i]);
         end
      end
      n_checks++;
      if (done_cnt != 1 || err_cnt != 0) begin
         n_fail++;
         $display("FAIL %s pulses: done=%0d err=%0d, required done=1 err=0", name, done_cnt, err_cnt);
      end
      n_checks++;
      if (rx_cyc.size() == 0 || done_cyc != rx_cyc[rx_cyc.size()-1] + 1) begin
         n_fail++;
         $display("FAIL %s done_timing: done at cycle %0d, required one after last rx handshake", name, done_cyc);
      end
      while (done_cnt > 0 && cyc < done_cyc + 1) @(negedge clk);
      n_checks++;
      if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s ready_after_done: ready=%b busy=%b, required ready=1 busy=0", name, req_ready_o, busy_o);
      end
      if (tx_si < 0 && rx_si < 0 && wr_q.size() == exp_q.size()) begin
         for (int i = 1; i < nb; i++) begin
            n_checks++;
            if (wr_cyc[3 + 2*i] - wr_cyc[1 + 2*i] != 6 + dly) begin
               n_fail++;
               $display("FAIL %s byte_period[%0d]: %0d cycles, required %0d", name, i,
                        wr_cyc[3 + 2*i] - wr_cyc[1 + 2*i], 6 + dly);
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [59:0] outs;
      repeat (3) @(negedge clk);
      outs = {req_ready_o, tx_ready_o, rx_valid_o, rx_data_o, busy_o, done_o, err_o,
              bus_addr_o, bus_wdata_o, bus_be_o, bus_we_o, bus_re_o};
      n_checks++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: %h, required all zero", outs);
      end
      rst_ni = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b busy=%b, required ready=1 busy=0", req_ready_o, busy_o);
      end
   endtask

   task automatic load_plan_bytes();
      tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C; tx_bytes[2] = 8'hFF;
      core_rx[0]  = 8'h11; core_rx[1]  = 8'h22; core_rx[2]  = 8'h33;
   endtask

   task automatic load_random_bytes();
      for (int i = 0; i < 256; i++) begin
         tx_bytes[i] = 8'($urandom);
         core_rx[i]  = 8'($urandom);
      end
   endtask

   task automatic test_basic();
      load_plan_bytes();
      run_xfer("basic", 8'd2, 20, -1, 0, -1, 0);
   endtask

   task automatic test_rx_stall();
      load_plan_bytes();
      run_xfer("rx_stall", 8'd2, 20, -1, 0, 0, 10);
   endtask

   task automatic test_tx_stall();
      load_plan_bytes();
      run_xfer("tx_stall", 8'd2, 20, 1, 15, -1, 0);
   endtask

   task automatic test_spurious_intr();
      load_random_bytes();
      spurious_arm = 1'b1;
      run_xfer("spurious_intr", 8'd1, 4, -1, 0, -1, 0);
      n_checks++;
      if (spurious_arm) begin
         n_fail++;
         $display("FAIL spurious_intr_applied: no DIV write seen to attach the pulse to, required one");
         spurious_arm = 1'b0;
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 5; t++) begin
         logic [7:0] len = 8'($urandom_range(0, 7));
         int tsi = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len) : -1;
         int rsi = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len) : -1;
         load_random_bytes();
         run_xfer("random", len, $urandom_range(1, 8), tsi, $urandom_range(1, 12),
                  rsi, $urandom_range(1, 12));
      end
   endtask

   task automatic test_max_len();
      load_random_bytes();
      run_xfer("max_len", 8'd255, 1, -1, 0, -1, 0);
   endtask

   task automatic test_reset_mid();
      logic [59:0] outs;
      int acc, n;
      load_random_bytes();
      clear_log();
      intr_delay = 3;
      send_desc(8'd3, 16'($urandom), 8'($urandom), $urandom, acc);
      tx_valid_i = 1'b1;
      tx_data_i  = tx_bytes[0];
      n = 0;
      while (wr_q.size() < 5 && n < 100) begin @(negedge clk); n++; end
      intr_delay = 0;
      n = 0;
      while (wr_q.size() < 7 && n < 100) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      n_checks++;
      if (wr_q.size() != 7 || rx_got.size() != 1 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_setup: writes=%0d rx=%0d busy=%b, required 7 writes 1 rx busy=1",
                  wr_q.size(), rx_got.size(), busy_o);
      end
      rst_ni = 1'b0;
      #1;
      outs = {req_ready_o, tx_ready_o, rx_valid_o, rx_data_o, busy_o, done_o, err_o,
              bus_addr_o, bus_wdata_o, bus_be_o, bus_we_o, bus_re_o};
      n_checks++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: %h, required all zero", outs);
      end
      tx_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || done_cnt != 0) begin
         n_fail++;
         $display("FAIL reset_mid_release: ready=%b busy=%b done=%0d, required ready=1 busy=0 done=0",
                  req_ready_o, busy_o, done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      load_random_bytes();
      run_xfer("b2b_min_0", 8'd0, 2, -1, 0, -1, 0);
      load_random_bytes();
      run_xfer("b2b_min_1", 8'd0, 1, -1, 0, -1, 0);
   endtask

`ifdef SPI_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] ctrl = $urandom;
      int acc, n, go_cyc, last;
      load_random_bytes();
      clear_log();
      intr_delay = 0;
      send_desc(8'd1, 16'($urandom), 8'($urandom), ctrl, acc);
      tx_valid_i = 1'b1;
      tx_data_i  = tx_bytes[0];
      n = 0;
      while (wr_q.size() < 5 && n < 50) begin @(negedge clk); n++; end
      tx_valid_i = 1'b0;
      go_cyc = (wr_q.size() >= 5) ? wr_cyc[4] : -1000;
      n = 0;
      while (err_cnt == 0 && n < 500) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      last = wr_q.size() - 1;
      n_checks++;
      if (wr_q.size() != 6 || wr_q[last] !== '{addr: CTRL_OFS, wdata: ctrl & ~GO_IE, be: 4'b1111}) begin
         n_fail++;
         $display("FAIL timeout_ctrl_write: writes=%0d last addr=%h data=%h, required 6 writes last CTRL data=%h",
                  wr_q.size(), wr_q[last].addr, wr_q[last].wdata, ctrl & ~GO_IE);
      end
      n_checks++;
      if (wr_cyc[last] != go_cyc + int'(TB_TIMEOUT) + 1 || err_cyc != wr_cyc[last]) begin
         n_fail++;
         $display("FAIL timeout_timing: write at %0d err at %0d, required both at %0d",
                  wr_cyc[last], err_cyc, go_cyc + int'(TB_TIMEOUT) + 1);
      end
      n_checks++;
      if (err_cnt != 1 || done_cnt != 0 || rx_got.size() != 0 || req_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_abort: err=%0d done=%0d rx=%0d ready=%b, required err=1 done=0 rx=0 ready=1",
                  err_cnt, done_cnt, rx_got.size(), req_ready_o);
      end
   endtask
`endif

   initial begin
      clear_log();
      strobe_cnt   = 0;
      intr_delay   = 0;
      countdown    = 0;
      rd_pend      = 1'b0;
      spurious_arm = 1'b0;
      test_reset();
      test_basic();
      test_rx_stall();
      test_tx_stall();
      test_spurious_intr();
      test_random();
      test_max_len();
      test_reset_mid();
      test_back_to_back();
`ifdef SPI_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
